// File: rtl/afe_sequencer_if.sv
// afe_sequencer_if: digital-pin bundle of the analog front-end sequencer.
//   ena        block enable (low aborts the running sequence)
//   start      sequence request
//   busy       sequencer is outside IDLE
//   done       one-cycle pulse, result valid
//   result     last majority decision
//   event_cnt  saturating count of positive decisions
// master: the controller that requests sequences; slave: the sequencer.
interface afe_sequencer_if;
  logic       ena;
  logic       start;
  logic       busy;
  logic       done;
  logic       result;
  logic [7:0] event_cnt;

  modport master (output ena, start, input busy, done, result, event_cnt);
  modport slave  (input ena, start, output busy, done, result, event_cnt);
endinterface

// File: rtl/afe_sequencer.sv
// afe_sequencer: powers the bias generator, lets the comparator settle,
// clears the sense latch, majority-votes the synchronised comparator over a
// sample window and, on a positive decision, pulses the LED stage and counts
// the event.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus (slave)     ena, start, busy, done, result, event_cnt
//   comp_in         raw asynchronous comparator output
//   bias_en         bias generator enable
//   comp_en         comparator enable
//   latch_clr       sense-latch clear, first sample cycle only
//   led_en          LED driver enable
// Configuration macro AFE_SEQ_AUTORUN_EN: when defined, start is level
// sensitive and a held start chains sequences back-to-back; otherwise a
// rising edge of start launches exactly one sequence.
module afe_sequencer #(
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLE_CYCLES = 8,
  parameter int LED_CYCLES    = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  afe_sequencer_if.slave bus,
  input  logic           comp_in,
  output logic           bias_en,
  output logic           comp_en,
  output logic           latch_clr,
  output logic           led_en
);

  localparam int MAX_A = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int MAX_P = (MAX_A > LED_CYCLES) ? MAX_A : LED_CYCLES;
  localparam int CW    = $clog2(MAX_P) + 1;
  localparam int HW    = $clog2(SAMPLE_CYCLES + 1);

  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] SAMPLE_LD = CW'(SAMPLE_CYCLES);
  localparam logic [CW-1:0] LED_LD    = CW'(LED_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [HW:0]   HALF_REF  = (HW+1)'(SAMPLE_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BIAS   = 3'd1,
    ST_COMP   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DECIDE = 3'd4,
    ST_LED    = 3'd5
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [HW-1:0] hits_r, hits_s;
  logic          sync1_r, comp_sync_r;
  logic          trigger_s, retrigger_s, expired_s, pos_s, decide_s;
  logic          bias_r, comp_r, clr_r, led_r, busy_r, done_r, result_r;
  logic [7:0]    event_cnt_r;

`ifdef AFE_SEQ_AUTORUN_EN
  // Level-sensitive request; a held start also chains the next sequence.
  assign trigger_s   = bus.start;
  assign retrigger_s = bus.start;
`else
  logic start_d_r;

  // Previous start level for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) start_d_r <= 1'b0;
    else        start_d_r <= bus.start;
  end

  assign trigger_s   = bus.start & ~start_d_r;
  assign retrigger_s = 1'b0;
`endif

  assign expired_s = (cnt_r == CNT_ONE);
  // Strict majority: 2*hits > window length, so a tie decides 0.
  assign pos_s     = ({1'b0, hits_r} << 1) > HALF_REF;
  assign decide_s  = (state_r == ST_DECIDE) && bus.ena;

  // Two-flop synchroniser for the asynchronous comparator output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r     <= 1'b0;
      comp_sync_r <= 1'b0;
    end else begin
      sync1_r     <= comp_in;
      comp_sync_r <= sync1_r;
    end
  end

  // State, shared down-counter and hit counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      hits_r  <= {HW{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      hits_r  <= hits_s;
    end
  end

  // Next-state, counter reload and hit accumulation
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    hits_s  = hits_r;
    if (!bus.ena) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (trigger_s) begin
            state_s = ST_BIAS;
            cnt_s   = SETTLE_LD;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_BIAS: begin
          if (expired_s) begin
            state_s = ST_COMP;
            cnt_s   = SETTLE_LD;
          end else begin
            cnt_s = cnt_r - CNT_ONE;
          end
        end
        ST_COMP: begin
          if (expired_s) begin
            state_s = ST_SAMPLE;
            cnt_s   = SAMPLE_LD;
            hits_s  = {HW{1'b0}};
          end else begin
            cnt_s = cnt_r - CNT_ONE;
          end
        end
        ST_SAMPLE: begin
          hits_s = hits_r + HW'(comp_sync_r);
          if (expired_s) begin
            state_s = ST_DECIDE;
          end else begin
            cnt_s = cnt_r - CNT_ONE;
          end
        end
        ST_DECIDE: begin
          if (pos_s) begin
            state_s = ST_LED;
            cnt_s   = LED_LD;
          end else if (retrigger_s) begin
            state_s = ST_BIAS;
            cnt_s   = SETTLE_LD;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_LED: begin
          if (expired_s) begin
            if (retrigger_s) begin
              state_s = ST_BIAS;
              cnt_s   = SETTLE_LD;
            end else begin
              state_s = ST_IDLE;
            end
          end else begin
            cnt_s = cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // Registered outputs decoded from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bias_r      <= 1'b0;
      comp_r      <= 1'b0;
      clr_r       <= 1'b0;
      led_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      result_r    <= 1'b0;
      event_cnt_r <= 8'd0;
    end else begin
      bias_r <= (state_s == ST_BIAS) || (state_s == ST_COMP) || (state_s == ST_SAMPLE);
      comp_r <= (state_s == ST_COMP) || (state_s == ST_SAMPLE);
      clr_r  <= (state_r == ST_COMP) && (state_s == ST_SAMPLE);
      led_r  <= (state_s == ST_LED);
      busy_r <= (state_s != ST_IDLE);
      done_r <= decide_s;
      if (decide_s) begin
        result_r <= pos_s;
        if (pos_s && (event_cnt_r != 8'hFF)) begin
          event_cnt_r <= event_cnt_r + 8'd1;
        end
      end
    end
  end

  assign bias_en       = bias_r;
  assign comp_en       = comp_r;
  assign latch_clr     = clr_r;
  assign led_en        = led_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.result    = result_r;
  assign bus.event_cnt = event_cnt_r;

endmodule

// File: tb/tb_afe_sequencer.sv
// tb_afe_sequencer: randomized bench for afe_sequencer with a timeline
// reference model (outputs derived from the cycle offset since the trigger).
// Honours AFE_SEQ_AUTORUN_EN the same way as the design.
module tb_afe_sequencer;
  localparam int S = 16;
  localparam int N = 8;
  localparam int L = 32;
  localparam int D = 2*S + N + 1;   // offset of the DECIDE cycle
`ifdef AFE_SEQ_AUTORUN_EN
  localparam bit AUTORUN = 1'b1;
`else
  localparam bit AUTORUN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic comp_in;
  logic bias_en, comp_en, latch_clr, led_en;

  afe_sequencer_if bus ();

  afe_sequencer #(.SETTLE_CYCLES(S), .SAMPLE_CYCLES(N), .LED_CYCLES(L)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .comp_in   (comp_in),
    .bias_en   (bias_en),
    .comp_en   (comp_en),
    .latch_clr (latch_clr),
    .led_en    (led_en)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model: state describing the cycle about to be observed
  bit       m_active, m_pos, m_done, m_result, m_start_prev;
  int       m_k, m_t0;
  int       m_cnt;
  bit       hist [1024];

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_pos = 1'b0; m_done = 1'b0; m_result = 1'b0;
    m_start_prev = 1'b0; m_k = 0; m_t0 = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit r, input bit st, input bit en, input bit ci);
    bit nd;
    bit end_seq;
    int h;
    hist[cyc % 1024] = ci;
    nd = 1'b0;
    end_seq = 1'b0;
    if (!r) begin
      model_reset();
    end else begin
      if (m_active) begin
        if (!en) begin
          m_active = 1'b0;
        end else if (m_k == D) begin
          // comp_sync in SAMPLE offsets 2S+1..2S+N comes from comp_in two cycles earlier
          h = 0;
          for (int i = 0; i < N; i++) h += int'(hist[(m_t0 + 2*S - 1 + i) % 1024]);
          m_pos = (2*h > N);
          nd = 1'b1;
          m_result = m_pos;
          if (m_pos && m_cnt < 255) m_cnt++;
          if (m_pos) m_k++;
          else end_seq = 1'b1;
        end else if (m_k == D + L) begin
          end_seq = 1'b1;
        end else begin
          m_k++;
        end
        if (end_seq) begin
          if (AUTORUN && st) begin
            m_t0 = cyc; m_k = 1; m_pos = 1'b0;
          end else begin
            m_active = 1'b0;
          end
        end
      end else begin
        if (en && (AUTORUN ? st : (st && !m_start_prev))) begin
          m_active = 1'b1; m_t0 = cyc; m_k = 1; m_pos = 1'b0;
        end
      end
      m_start_prev = st;
    end
    m_done = nd;
  endtask

  task automatic do_cycle(input bit r, input bit st, input bit en, input bit ci);
    bit e_bias, e_comp, e_clr, e_led;
    @(negedge clk);
    e_bias = m_active && m_k >= 1 && m_k <= 2*S + N;
    e_comp = m_active && m_k >= S + 1 && m_k <= 2*S + N;
    e_clr  = m_active && m_k == 2*S + 1;
    e_led  = m_active && m_pos && m_k >= D + 1 && m_k <= D + L;
    check_eq("bias_en",   8'(bias_en),       8'(e_bias));
    check_eq("comp_en",   8'(comp_en),       8'(e_comp));
    check_eq("latch_clr", 8'(latch_clr),     8'(e_clr));
    check_eq("led_en",    8'(led_en),        8'(e_led));
    check_eq("busy",      8'(bus.busy),      8'(m_active));
    check_eq("done",      8'(bus.done),      8'(m_done));
    check_eq("result",    8'(bus.result),    8'(m_result));
    check_eq("event_cnt", bus.event_cnt,     8'(m_cnt));
    rst_n = r; bus.start = st; bus.ena = en; comp_in = ci;
    if (!r) begin
      #1;
      check_eq("rst_bias",  8'(bias_en),   8'd0);
      check_eq("rst_comp",  8'(comp_en),   8'd0);
      check_eq("rst_clr",   8'(latch_clr), 8'd0);
      check_eq("rst_led",   8'(led_en),    8'd0);
      check_eq("rst_busy",  8'(bus.busy),  8'd0);
      check_eq("rst_done",  8'(bus.done),  8'd0);
      check_eq("rst_res",   8'(bus.result), 8'd0);
      check_eq("rst_cnt",   bus.event_cnt, 8'd0);
    end
    model_step(r, st, en, ci);
    cyc++;
  endtask

  // hits < 0: random window; fill 0/1 constant outside window, 2 random
  task automatic run_seq(input int hits, input int fill, input int abort_at);
    bit win [N];
    bit ci;
    bit tmp;
    int j;
    for (int i = 0; i < N; i++) win[i] = (hits < 0) ? bit'($urandom % 2) : (i < hits);
    for (int i = N - 1; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = win[i]; win[i] = win[j]; win[j] = tmp;
    end
    for (int off = 0; off <= D + L + 3; off++) begin
      if (off >= 2*S - 1 && off <= 2*S + N - 2) ci = win[off - (2*S - 1)];
      else if (fill == 2) ci = bit'($urandom % 2);
      else ci = (fill == 1);
      do_cycle(1'b1, off == 0, off != abort_at, ci);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; bus.start = 1'b0; bus.ena = 1'b0; comp_in = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, 1'b1, 1'b0);

    run_seq(N, 1, -1);          // comp_in held high: positive
    run_seq(0, 0, -1);          // comp_in held low: negative
    run_seq(N/2, 2, -1);        // tie decides 0
    run_seq(N/2 + 1, 2, -1);    // strict majority decides 1
    run_seq(N, 1, 20);          // abort in COMP
    run_seq(N, 1, -1);          // full sequence after abort
    run_seq(N, 1, D);           // abort in DECIDE: no done
    for (int i = 0; i < 10; i++) run_seq(-1, 2, (($urandom % 4) == 0) ? int'($urandom_range(D + L, 1)) : -1);

    for (int i = 0; i < 260; i++) run_seq(N, 2, -1);
    @(negedge clk);
    check_eq("saturated", bus.event_cnt, 8'd255);

    // reset in the middle of SAMPLE, then start held high
    for (int off = 0; off < 36; off++) do_cycle(1'b1, off == 0, 1'b1, bit'($urandom % 2));
    do_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3*(D + L + 1) + 10; i++) do_cycle(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < D + L + 5; i++) do_cycle(1'b1, 1'b0, 1'b1, bit'($urandom % 2));
    run_seq(-1, 2, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/afe_sequencer.md
# afe_sequencer

Digital sequencer for the analog front end: it powers up the bias generator, lets the comparator settle, clears the sense latch, then majority-votes the comparator output over a sample window. On a positive decision it drives the LED stage for a fixed pulse and counts events. It sits between the top-level digital pins (start, status, event count) and the enable/clear pins of the analog macros.

## Interface
- SETTLE_CYCLES, 16, cycles spent in each settle state (BIAS, COMP); ≥1
- SAMPLE_CYCLES, 8, comparator sample window length; ≥1
- LED_CYCLES, 32, LED pulse length on positive decision; ≥1
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- ena  in  1  block enable; low forces abort
- start  in  1  sequence request (edge- or level-triggered, see Configuration)
- comp_in  in  1  raw asynchronous comparator output
- bias_en  out  1  bias generator enable
- comp_en  out  1  comparator enable
- latch_clr  out  1  sense-latch clear pulse
- led_en  out  1  LED driver enable
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse, result valid
- result  out  1  last decision (1 = comparator majority high)
- event_cnt  out  8  saturating count of positive decisions

## Operation
- comp_in passes a 2-FF synchronizer before use; only comp_sync is sampled.
- States: IDLE, BIAS, COMP, SAMPLE, DECIDE, LED. One shared down-counter (width $clog2 of the largest parameter + 1) plus a hits counter ($clog2(SAMPLE_CYCLES+1) bits).
- IDLE: all enables 0. Trigger (see Configuration) → BIAS, counter loaded SETTLE_CYCLES.
- BIAS: bias_en=1. Counter reaches 1 → COMP, reload SETTLE_CYCLES.
- COMP: bias_en=comp_en=1. Expiry → SAMPLE, reload SAMPLE_CYCLES, hits cleared.
- SAMPLE: bias_en=comp_en=1; latch_clr=1 on the first SAMPLE cycle only; hits += comp_sync each cycle. Expiry → DECIDE.
- DECIDE (1 cycle): result_next = (2*hits > SAMPLE_CYCLES); ties decide 0. Positive → event_cnt += 1, saturating at 255. → LED (reload LED_CYCLES) if positive, else IDLE.
- LED: led_en=1, bias/comp off. Expiry → IDLE.
- ena low in any state: next state IDLE, all enables 0 next cycle, no done pulse, result/event_cnt unchanged.
- start changes during a busy sequence are ignored (except the autorun check on LED/DECIDE exit).

## Timing
- Reset values: state IDLE; bias_en, comp_en, latch_clr, led_en, busy, done, result = 0; event_cnt = 0; synchronizer flops 0.
- All outputs registered (Moore, decoded from registered state/flags).
- Trigger sampled at cycle 0 → BIAS in cycles 1..S, COMP in S+1..2S, SAMPLE in 2S+1..2S+N, DECIDE at 2S+N+1.
- done=1 and result updated in cycle 2S+N+2 (the cycle after DECIDE); event_cnt updates the same cycle.
- LED: led_en high cycles 2S+N+2 .. 2S+N+L+1; IDLE at 2S+N+L+2. Negative decision: IDLE at 2S+N+2.
- comp_in change reaches comp_sync 2 cycles later; bench must account for it in sample-window alignment.
- Reset mid-sequence: all outputs to reset values immediately (asynchronous); the event count is lost.

## Configuration
- AFE_SEQ_AUTORUN_EN defined: start is level-sensitive; in IDLE, start=1 triggers; at exit of LED or negative DECIDE, if start=1 and ena=1, next state is BIAS directly (skipping IDLE), giving back-to-back sequences.
- Undefined: start is rising-edge triggered (registered start_d, trigger = start & ~start_d, evaluated in IDLE only); exactly one sequence per edge; always returns to IDLE.

## Test plan
- Defaults, comp_in held 1, start edge at cycle 0 → bias_en rises cycle 1, comp_en cycle 17, latch_clr single pulse cycle 33, done+result=1 cycle 42, led_en cycles 42..73, event_cnt=1, busy low cycle 74.
- comp_in held 0 → done at cycle 42 with result=0, led_en never asserted, event_cnt unchanged, IDLE cycle 42.
- comp_sync high for exactly 4 of 8 sample cycles → result=0 (tie); 5 of 8 → result=1.
- ena dropped at cycle 20 (COMP) → all enables 0 by cycle 21, no done, result/event_cnt hold; next start edge runs a full sequence.
- 260 positive sequences → event_cnt saturates at 255, holds.
- rst_n asserted mid-SAMPLE → outputs zero asynchronously; with AUTORUN_EN and start held 1 after release, sequences repeat back-to-back (bias_en rises cycle after each LED expiry); without it, start held high gives only one sequence.
